mips_multicycle_control_32: RTL and testbench

Multicycle main control FSM for the 32-bit MIPS datapath. Decodes the instruction opcode (and `func` for `jr`), sequences fetch/decode/execute/memory/writeback, and drives every datapath enable and mux select. It also drives the 2-bit `alu_op` consumed directly by `alu_control_32`. Memory accesses stall on a `mem_ready` handshake.

---
 rtl/mips_multicycle_control_32.sv | 214 +++++++++++++++++++++
 tb/tb_mips_multicycle_control_32.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control_32.sv
// Multicycle main control FSM for the 32-bit MIPS datapath: Moore controls, mem_ready stalls.
// Optional feature: define MC_ADDI_EN to decode addi through ADDI_EXEC/ADDI_WB.
module mips_multicycle_control_32 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       err_illegal_opcode,
    output logic [3:0] state
);

`ifdef MC_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FUNC_JR  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JR        = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       err_illegal_opcode;
    } ctrl_t;

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] opcode_reg;
    ctrl_t      ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // The opcode is captured in DECODE so MEM_ADDR can split lw/sw without relying on IR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_reg <= 6'd0;
        end else if (state_reg == S_DECODE) begin
            opcode_reg <= opcode;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        ctrl       = '0;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = 2'b00;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                state_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = 2'b00;
                case (opcode)
                    OP_RTYPE:     state_next = (func == FUNC_JR) ? S_JR : S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI: begin
                        if (ADDI_EN) begin
                            state_next = S_ADDI_EXEC;
                        end else begin
                            ctrl.err_illegal_opcode = 1'b1;
                        end
                    end
                    default:      ctrl.err_illegal_opcode = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                state_next     = (opcode_reg == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_next    = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
                state_next      = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = 2'b10;
                state_next     = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
            end
            S_JR: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b11;
                ctrl.instr_done = 1'b1;
            end
            // Without the addi feature these two codes fall back to the idle behaviour.
            S_ADDI_EXEC: begin
                if (ADDI_EN) begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                    state_next     = S_ADDI_WB;
                end
            end
            S_ADDI_WB: begin
                if (ADDI_EN) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low combinationally while reset is held, so no enable survives it.
    assign pc_write           = rst_n & ctrl.pc_write;
    assign pc_write_cond      = rst_n & ctrl.pc_write_cond;
    assign i_or_d             = rst_n & ctrl.i_or_d;
    assign mem_read           = rst_n & ctrl.mem_read;
    assign mem_write          = rst_n & ctrl.mem_write;
    assign ir_write           = rst_n & ctrl.ir_write;
    assign mem_to_reg         = rst_n & ctrl.mem_to_reg;
    assign reg_dst            = rst_n & ctrl.reg_dst;
    assign reg_write          = rst_n & ctrl.reg_write;
    assign alu_src_a          = rst_n & ctrl.alu_src_a;
    assign alu_src_b          = rst_n ? ctrl.alu_src_b : 2'b00;
    assign pc_source          = rst_n ? ctrl.pc_source : 2'b00;
    assign alu_op             = rst_n ? ctrl.alu_op : 2'b00;
    assign instr_done         = rst_n & ctrl.instr_done;
    assign err_illegal_opcode = rst_n & ctrl.err_illegal_opcode;
    assign state              = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control_32.sv
// Self-checking bench for mips_multicycle_control_32: vector table, hand-written corner cases,
// and randomized instruction streams checked against a path/lookup reference model.
module tb_mips_multicycle_control_32;

`ifdef MC_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       err;
    } ctrl_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ill;
        logic [3:0]  n;
        logic [23:0] seq;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, alu_op;
    logic       instr_done, err_illegal_opcode;
    logic [3:0] state;
    ctrl_t      ctrl_dut;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mips_multicycle_control_32 dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .instr_done(instr_done), .err_illegal_opcode(err_illegal_opcode),
        .state(state)
    );

    assign ctrl_dut = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                       alu_op, instr_done, err_illegal_opcode};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Control word each state is documented to drive.
    function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic ill);
        ctrl_t c;
        c = '0;
        case (st)
            0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            1: begin c.alu_src_b = 2'b11; c.err = ill; end
            2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3: begin c.mem_read = 1; c.i_or_d = 1; end
            4: begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            5: begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = mr; end
            6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7: begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
            8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                     c.pc_source = 2'b01; c.instr_done = 1; end
            9: begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            10: if (ADDI_EN) begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            11: if (ADDI_EN) begin c.reg_write = 1; c.instr_done = 1; end
            12: begin c.pc_write = 1; c.pc_source = 2'b11; c.instr_done = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_illegal(input logic [5:0] op);
        return !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                 op == 6'b000100 || op == 6'b000010 || (op == 6'b001000 && ADDI_EN));
    endfunction

    function automatic logic [23:0] pack6(input int s0, s1, s2, s3, s4, s5);
        return {4'(s5), 4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
    endfunction

    // One clock cycle: drive inputs, sample mid-cycle, compare, advance to just after the edge.
    task automatic cyc(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                       input int exp_st, input logic ill, input string tag);
        mem_ready = mr;
        opcode    = op;
        func      = fn;
        #4;
        check({tag, " state"}, 32'(state), 32'(exp_st));
        check({tag, " ctrl"}, 32'(ctrl_dut), 32'(exp_ctrl(exp_st, mr, ill)));
        if (instr_done === 1'b1) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reference: the list of states an instruction visits; FETCH/MEM_READ/MEM_WRITE repeat on stall.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stall_pct,
                             input string tag);
        int   path[$];
        int   idx;
        int   guard;
        logic mr;
        logic ill;
        ill   = is_illegal(op);
        path  = {0, 1};
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) path.push_back(12);
                else begin path.push_back(6); path.push_back(7); end
            end
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000100: path.push_back(8);
            6'b000010: path.push_back(9);
            6'b001000: if (ADDI_EN) begin path.push_back(10); path.push_back(11); end
            default: ;
        endcase
        idx      = 0;
        guard    = 0;
        done_cnt = 0;
        while (idx < path.size()) begin
            mr = ($urandom_range(99) < 32'(stall_pct)) ? 1'b0 : 1'b1;
            // After DECODE the IR inputs are scrambled: the FSM must rely on its latched opcode.
            if (idx <= 1) cyc(mr, op, fn, path[idx], ill, tag);
            else          cyc(mr, 6'($urandom), 6'($urandom), path[idx], ill, tag);
            if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mr)) idx++;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got %0d cycles required <= 200", tag, guard);
                break;
            end
        end
        check({tag, " done pulses"}, 32'(done_cnt), ill ? 32'd0 : 32'd1);
        $display("instr %s op=%b fn=%b cycles=%0d", tag, op, fn, guard);
    endtask

    vec_t vecs[10];

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b100011;
        func      = 6'd0;

        vecs[0] = '{op: 6'b100011, fn: 6'd0,       ill: 0, n: 5, seq: pack6(0, 1, 2, 3, 4, 0)};
        vecs[1] = '{op: 6'b101011, fn: 6'd0,       ill: 0, n: 4, seq: pack6(0, 1, 2, 5, 0, 0)};
        vecs[2] = '{op: 6'b000000, fn: 6'b100000,  ill: 0, n: 4, seq: pack6(0, 1, 6, 7, 0, 0)};
        vecs[3] = '{op: 6'b000000, fn: 6'b001000,  ill: 0, n: 3, seq: pack6(0, 1, 12, 0, 0, 0)};
        vecs[4] = '{op: 6'b000100, fn: 6'd0,       ill: 0, n: 3, seq: pack6(0, 1, 8, 0, 0, 0)};
        vecs[5] = '{op: 6'b000010, fn: 6'd0,       ill: 0, n: 3, seq: pack6(0, 1, 9, 0, 0, 0)};
        vecs[6] = '{op: 6'b111111, fn: 6'd0,       ill: 1, n: 2, seq: pack6(0, 1, 0, 0, 0, 0)};
        vecs[7] = '{op: 6'b000001, fn: 6'b001000,  ill: 1, n: 2, seq: pack6(0, 1, 0, 0, 0, 0)};
        vecs[8] = '{op: 6'b000000, fn: 6'b101010,  ill: 0, n: 4, seq: pack6(0, 1, 6, 7, 0, 0)};
        if (ADDI_EN)
            vecs[9] = '{op: 6'b001000, fn: 6'd0, ill: 0, n: 4, seq: pack6(0, 1, 10, 11, 0, 0)};
        else
            vecs[9] = '{op: 6'b001000, fn: 6'd0, ill: 1, n: 2, seq: pack6(0, 1, 0, 0, 0, 0)};

        // Reset held for three cycles: FETCH state, every output low.
        repeat (3) begin
            @(posedge clk);
            #4;
            check("reset state", 32'(state), 32'd0);
            check("reset ctrl", 32'(ctrl_dut), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-wait vector table; row 0 also covers the first FETCH after reset release.
        for (int r = 0; r < 10; r++) begin
            done_cnt = 0;
            for (int i = 0; i < int'(vecs[r].n); i++) begin
                cyc(1'b1, vecs[r].op, vecs[r].fn, int'(vecs[r].seq[4*i +: 4]), vecs[r].ill,
                    $sformatf("vec%0d", r));
            end
            check($sformatf("vec%0d done pulses", r), 32'(done_cnt), vecs[r].ill ? 32'd0 : 32'd1);
            $display("vector %0d op=%b fn=%b cycles=%0d", r, vecs[r].op, vecs[r].fn, vecs[r].n);
        end

        // sw with three wait cycles in MEM_WRITE.
        done_cnt = 0;
        cyc(1'b1, 6'b101011, 6'd0, 0, 1'b0, "sw_stall");
        cyc(1'b1, 6'b101011, 6'd0, 1, 1'b0, "sw_stall");
        cyc(1'b1, 6'b101011, 6'd0, 2, 1'b0, "sw_stall");
        repeat (3) cyc(1'b0, 6'b101011, 6'd0, 5, 1'b0, "sw_stall");
        cyc(1'b1, 6'b101011, 6'd0, 5, 1'b0, "sw_stall");
        check("sw_stall done pulses", 32'(done_cnt), 32'd1);
        $display("instr sw_stall op=101011 cycles=7");

        // Reset asserted while lw waits in MEM_READ.
        cyc(1'b1, 6'b100011, 6'd0, 0, 1'b0, "lw_rst");
        cyc(1'b1, 6'b100011, 6'd0, 1, 1'b0, "lw_rst");
        cyc(1'b1, 6'b100011, 6'd0, 2, 1'b0, "lw_rst");
        mem_ready = 1'b0;
        #2;
        check("lw_rst memread state", 32'(state), 32'd3);
        check("lw_rst memread ctrl", 32'(ctrl_dut), 32'(exp_ctrl(3, 1'b0, 1'b0)));
        rst_n = 1'b0;
        #1;
        check("lw_rst abort state", 32'(state), 32'd0);
        check("lw_rst abort ctrl", 32'(ctrl_dut), 32'd0);
        @(posedge clk);
        #2;
        check("lw_rst held ctrl", 32'(ctrl_dut), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(6'b100011, 6'd0, 0, "lw_restart");

        // Randomized instruction stream with random memory stalls.
        for (int k = 0; k < 300; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            fn = 6'($urandom);
            case ($urandom_range(9))
                0: op = 6'b000000;
                1: begin op = 6'b000000; fn = 6'b001000; end
                2, 9: op = 6'b100011;
                3: op = 6'b101011;
                4: op = 6'b000100;
                5: op = 6'b000010;
                6: op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, 35, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
